// File: rtl/alu_rs_pkg.sv
// Shared ALU reservation station definitions: widths, alu_bus layout, simp_op codes.
// The decoder and the ALU import this package too.
package alu_rs_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = 3;
    localparam int unsigned LOCK_W  = 4;

    // A lock equal to NO_LOCK means the operand value is already present
    localparam logic [LOCK_W-1:0] NO_LOCK = LOCK_W'(1) << ENTRY_W;

    localparam int unsigned BUS_W = OP_W + 2 * (LOCK_W + DATA_W) + ENTRY_W;

    localparam int unsigned TAG_LSB   = 0;
    localparam int unsigned DATA2_LSB = TAG_LSB + ENTRY_W;
    localparam int unsigned LOCK2_LSB = DATA2_LSB + DATA_W;
    localparam int unsigned DATA1_LSB = LOCK2_LSB + LOCK_W;
    localparam int unsigned LOCK1_LSB = DATA1_LSB + DATA_W;
    localparam int unsigned OP_LSB    = LOCK1_LSB + LOCK_W;

    typedef enum logic [OP_W-1:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu,
        OpLui, OpAuipc, OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu, OpJal, OpJalr
    } simp_op_e;

    // Field order matches alu_bus, MSB first
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [LOCK_W-1:0]  lock1;
        logic [DATA_W-1:0]  data1;
        logic [LOCK_W-1:0]  lock2;
        logic [DATA_W-1:0]  data2;
        logic [ENTRY_W-1:0] tag;
    } alu_req_t;

    localparam alu_req_t REQ_RESET = '{
        op: '0, lock1: NO_LOCK, data1: '0, lock2: NO_LOCK, data2: '0, tag: '0
    };

    function automatic logic lock_hit(input logic [LOCK_W-1:0]  lock,
                                      input logic               cdb_valid,
                                      input logic [ENTRY_W-1:0] cdb_tag);
        return cdb_valid && (lock != NO_LOCK) && (lock[ENTRY_W-1:0] == cdb_tag);
    endfunction

endpackage

// File: rtl/alu_rs_entry.sv
// One reservation station slot: stores a decoded op and captures missing operands
// from the CDB, either at allocation or while resident.
module alu_rs_entry
    import alu_rs_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               alloc_i,
    input  logic               free_i,
    input  alu_req_t           req_i,
    input  logic               cdb_valid_i,
    input  logic [ENTRY_W-1:0] cdb_tag_i,
    input  logic [DATA_W-1:0]  cdb_data_i,
    output logic               valid_o,
    output logic               ready_o,
    output logic [OP_W-1:0]    op_o,
    output logic [DATA_W-1:0]  a_o,
    output logic [DATA_W-1:0]  b_o,
    output logic [ENTRY_W-1:0] tag_o
);

    logic     valid_q, valid_d;
    alu_req_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else begin
            if (alloc_i) begin
                valid_d = 1'b1;
                entry_d = req_i;
            end else if (free_i) begin
                valid_d = 1'b0;
            end
            // The same compare serves allocation-time capture and resident wakeup
            if (alloc_i || valid_q) begin
                if (lock_hit(entry_d.lock1, cdb_valid_i, cdb_tag_i)) begin
                    entry_d.lock1 = NO_LOCK;
                    entry_d.data1 = cdb_data_i;
                end
                if (lock_hit(entry_d.lock2, cdb_valid_i, cdb_tag_i)) begin
                    entry_d.lock2 = NO_LOCK;
                    entry_d.data2 = cdb_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            entry_q <= REQ_RESET;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = valid_q && (entry_q.lock1 == NO_LOCK) && (entry_q.lock2 == NO_LOCK);
    assign op_o    = entry_q.op;
    assign a_o     = entry_q.data1;
    assign b_o     = entry_q.data2;
    assign tag_o   = entry_q.tag;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: allocates into the lowest free slot, issues the lowest
// ready slot, and stalls the decoder while every slot is occupied.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alu_write,
    input  logic [BUS_W-1:0]   alu_bus,
    output logic               alu_stall,
    input  logic               cdb_valid,
    input  logic [ENTRY_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [OP_W-1:0]    ex_op,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [ENTRY_W-1:0] ex_tag
);

    localparam int unsigned CntW = $clog2(ENTRIES + 1);

    alu_req_t           req;
    logic [ENTRIES-1:0] valid, ready;
    logic [ENTRIES-1:0] alloc_sel, issue_sel, alloc_vec, free_vec;
    logic [CntW-1:0]    count;
    logic [OP_W-1:0]    e_op  [ENTRIES];
    logic [DATA_W-1:0]  e_a   [ENTRIES];
    logic [DATA_W-1:0]  e_b   [ENTRIES];
    logic [ENTRY_W-1:0] e_tag [ENTRIES];

    assign req = alu_req_t'(alu_bus);

    always_comb begin
        count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            count = count + CntW'(valid[i]);
        end
    end

    // Full stall is taken from registered occupancy only; a same-cycle issue does not lift it
    assign alu_stall = (count == CntW'(ENTRIES));

    // Isolate the lowest clear / lowest set bit
    assign alloc_sel = ~valid & (valid + ENTRIES'(1));
    assign issue_sel = ready & (~ready + ENTRIES'(1));

    assign alloc_vec = (alu_write && !alu_stall && !flush) ? alloc_sel : '0;
    assign ex_valid  = |ready;
    assign free_vec  = (ex_valid && ex_ready) ? issue_sel : '0;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        alu_rs_entry u_entry (
            .clk_i       (clk),
            .rst_ni      (rst),
            .flush_i     (flush),
            .alloc_i     (alloc_vec[i]),
            .free_i      (free_vec[i]),
            .req_i       (req),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .valid_o     (valid[i]),
            .ready_o     (ready[i]),
            .op_o        (e_op[i]),
            .a_o         (e_a[i]),
            .b_o         (e_b[i]),
            .tag_o       (e_tag[i])
        );
    end

    always_comb begin
        ex_op  = '0;
        ex_a   = '0;
        ex_b   = '0;
        ex_tag = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_sel[i]) begin
                ex_op  = e_op[i];
                ex_a   = e_a[i];
                ex_b   = e_b[i];
                ex_tag = e_tag[i];
            end
        end
    end

endmodule
